// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared types and constants for the RGB LCD power-up / configuration
// sequencer: sequencer state enum, strap decode table entries (panel ID and
// active resolution), pixel-clock select encodings and the counter reload
// helper.
// -----------------------------------------------------------------------------
package lcd_pkg;

   // Width of the shared state down-counter.
   localparam int CNT_W = 20;

   typedef enum logic [2:0] {
      ST_SETTLE   = 3'd0,
      ST_SAMPLE_A = 3'd1,
      ST_SAMPLE_B = 3'd2,
      ST_RST_LOW  = 3'd3,
      ST_WAKE     = 3'd4,
      ST_BL_DLY   = 3'd5,
      ST_RUN      = 3'd6
   } lcd_state_e;

   // Strap code that falls through to the unknown-panel defaults; used to
   // force the fallback decode once sample retries are exhausted.
   localparam logic [2:0] STRAP_UNKNOWN = 3'b111;

   // Panel IDs by strap code (M2M1M0).
   localparam logic [15:0] ID_S000    = 16'h4342;
   localparam logic [15:0] ID_S001    = 16'h7084;
   localparam logic [15:0] ID_S010    = 16'h7016;
   localparam logic [15:0] ID_S100    = 16'h4384;
   localparam logic [15:0] ID_S101    = 16'h1018;
   localparam logic [15:0] ID_UNKNOWN = 16'h0000;

   // Active resolutions.
   localparam logic [10:0] H_480  = 11'd480;
   localparam logic [10:0] V_272  = 11'd272;
   localparam logic [10:0] H_800  = 11'd800;
   localparam logic [10:0] V_480  = 11'd480;
   localparam logic [10:0] H_1024 = 11'd1024;
   localparam logic [10:0] V_600  = 11'd600;
   localparam logic [10:0] H_1280 = 11'd1280;
   localparam logic [10:0] V_800  = 11'd800;

   // Pixel-clock select encodings for the divider.
   localparam logic [1:0] PCLK_SEL_480X272  = 2'd0;
   localparam logic [1:0] PCLK_SEL_800X480  = 2'd1;
   localparam logic [1:0] PCLK_SEL_1024X600 = 2'd2;
   localparam logic [1:0] PCLK_SEL_1280X800 = 2'd3;

   // Reload value for a state lasting n cycles: the state exits on the cycle
   // the counter reads zero, so load n-1; n=0 behaves like n=1.
   function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
      logic [CNT_W-1:0] ld;
      if (n == 32'd0) begin
         ld = 20'd0;
      end else begin
         ld = CNT_W'(n - 32'd1);
      end
      return ld;
   endfunction

endpackage

// File: rtl/lcd_strap_decode.sv
// -----------------------------------------------------------------------------
// lcd_strap_decode
// Combinational panel strap decoder.
//   strap    in  3  : {M2,M1,M0}
//   lcd_id   out 16 : panel ID (0x0000 for unrecognised codes)
//   h_disp   out 11 : active width
//   v_disp   out 11 : active height
//   pclk_sel out 2  : pixel-clock select
// -----------------------------------------------------------------------------
module lcd_strap_decode
   import lcd_pkg::*;
(
   input  logic [2:0]  strap,
   output logic [15:0] lcd_id,
   output logic [10:0] h_disp,
   output logic [10:0] v_disp,
   output logic [1:0]  pclk_sel
);

   // Strap code to panel configuration table.
   always_comb begin
      lcd_id   = ID_UNKNOWN;
      h_disp   = H_480;
      v_disp   = V_272;
      pclk_sel = PCLK_SEL_480X272;
      case (strap)
         3'b000: begin
            lcd_id = ID_S000; h_disp = H_480;  v_disp = V_272; pclk_sel = PCLK_SEL_480X272;
         end
         3'b001: begin
            lcd_id = ID_S001; h_disp = H_800;  v_disp = V_480; pclk_sel = PCLK_SEL_800X480;
         end
         3'b010: begin
            lcd_id = ID_S010; h_disp = H_1024; v_disp = V_600; pclk_sel = PCLK_SEL_1024X600;
         end
         3'b100: begin
            lcd_id = ID_S100; h_disp = H_800;  v_disp = V_480; pclk_sel = PCLK_SEL_800X480;
         end
         3'b101: begin
            lcd_id = ID_S101; h_disp = H_1280; v_disp = V_800; pclk_sel = PCLK_SEL_1280X800;
         end
         default: begin
            lcd_id = ID_UNKNOWN; h_disp = H_480; v_disp = V_272; pclk_sel = PCLK_SEL_480X272;
         end
      endcase
   end

endmodule

// File: rtl/lcd_panel_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_panel_ctrl
// Power-up and configuration sequencer for the RGB LCD path (sys_clk domain).
// Keeps the RGB pads released while the panel straps on lcd_rgb_i[23/15/7]
// are sampled twice and decoded, then sequences panel reset, display enable
// and backlight.
//   sys_clk, sys_rst  : clock, synchronous active-high reset
//   restart           : pulse, re-runs the whole sequence
//   lcd_rgb_i[23:0]   : pad input side of the RGB IOBUFs (straps)
//   bl_duty[7:0]      : backlight duty (LCD_BL_PWM_EN builds only)
//   rgb_oe            : 1 = drive RGB pads (IOBUF T = ~rgb_oe)
//   lcd_id, h_disp, v_disp, pclk_sel : decoded configuration, gate on id_valid
//   id_valid          : configuration outputs are stable
//   lcd_rst           : panel reset, active-low
//   disp_en           : timing generator enable
//   lcd_bl            : backlight
// Build option: define LCD_BL_PWM_EN for a PWM-dimmed backlight in RUN;
// otherwise lcd_bl is simply on in RUN and bl_duty is ignored.
// All outputs are registered from the current state.
// -----------------------------------------------------------------------------
module lcd_panel_ctrl #(
   parameter int unsigned SETTLE_CYC = 1000,
   parameter int unsigned SAMPLE_GAP = 64,
   parameter int unsigned MAX_RETRY  = 7,
   parameter int unsigned RST_CYC    = 5000,
   parameter int unsigned WAKE_CYC   = 250000,
   parameter int unsigned BL_DLY_CYC = 10000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        restart,
   input  logic [23:0] lcd_rgb_i,
   input  logic [7:0]  bl_duty,
   output logic        rgb_oe,
   output logic [15:0] lcd_id,
   output logic        id_valid,
   output logic [10:0] h_disp,
   output logic [10:0] v_disp,
   output logic [1:0]  pclk_sel,
   output logic        lcd_rst,
   output logic        disp_en,
   output logic        lcd_bl
);
   import lcd_pkg::*;

   localparam int RETRY_W = (MAX_RETRY < 32'd1) ? 1 : $clog2(MAX_RETRY + 32'd1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   localparam logic [CNT_W-1:0] SETTLE_LD = cyc_load(SETTLE_CYC);
   localparam logic [CNT_W-1:0] GAP_LD    = cyc_load(SAMPLE_GAP);
   localparam logic [CNT_W-1:0] RST_LD    = cyc_load(RST_CYC);
   localparam logic [CNT_W-1:0] WAKE_LD   = cyc_load(WAKE_CYC);
   localparam logic [CNT_W-1:0] BL_LD     = cyc_load(BL_DLY_CYC);

   lcd_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [2:0]         strap_a_q, strap_a_d, strap_b_q, strap_b_d;

   logic        rgb_oe_q, rgb_oe_d, id_valid_q, id_valid_d;
   logic        lcd_rst_q, lcd_rst_d, disp_en_q, disp_en_d, lcd_bl_q, lcd_bl_d;
   logic [15:0] lcd_id_q, lcd_id_d;
   logic [10:0] h_disp_q, h_disp_d, v_disp_q, v_disp_d;
   logic [1:0]  pclk_sel_q, pclk_sel_d;

   logic [2:0]  strap_in_s, dec_strap_s;
   logic        match_s, proceed_s, bl_on_s;
   logic [15:0] dec_id_s;
   logic [10:0] dec_h_s, dec_v_s;
   logic [1:0]  dec_pclk_s;

   assign strap_in_s  = {lcd_rgb_i[23], lcd_rgb_i[15], lcd_rgb_i[7]};
   assign match_s     = (strap_a_q == strap_b_q);
   // Proceed on a confirmed strap, or give up and use the unknown default.
   assign proceed_s   = match_s || (retry_q == RETRY_MAX);
   assign dec_strap_s = match_s ? strap_a_q : STRAP_UNKNOWN;

   lcd_strap_decode u_decode (
      .strap    (dec_strap_s),
      .lcd_id   (dec_id_s),
      .h_disp   (dec_h_s),
      .v_disp   (dec_v_s),
      .pclk_sel (dec_pclk_s)
   );

`ifdef LCD_BL_PWM_EN
   logic [7:0] pwm_cnt_q, pwm_cnt_d;

   // Free-running PWM phase counter.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
   end

   // PWM phase register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pwm_cnt_q <= 8'd0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

   assign bl_on_s = (pwm_cnt_q < bl_duty);
`else
   logic unused_bl_duty_s;
   assign unused_bl_duty_s = ^bl_duty;
   assign bl_on_s = 1'b1;
`endif

   // Sequencer next state, shared down-counter, strap capture and retry count.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retry_d   = retry_q;
      strap_a_d = strap_a_q;
      strap_b_d = strap_b_q;
      if (restart) begin
         state_d = ST_SETTLE;
         cnt_d   = SETTLE_LD;
         // Restart inside SETTLE only re-arms the settle time.
         if (state_q != ST_SETTLE) begin
            retry_d = {RETRY_W{1'b0}};
         end else begin
            retry_d = retry_q;
         end
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (cnt_q == 20'd0) begin
                  strap_a_d = strap_in_s;
                  state_d   = ST_SAMPLE_A;
                  cnt_d     = GAP_LD;
               end else begin
                  cnt_d = cnt_q - 20'd1;
               end
            end
            ST_SAMPLE_A: begin
               if (cnt_q == 20'd0) begin
                  strap_b_d = strap_in_s;
                  state_d   = ST_SAMPLE_B;
                  cnt_d     = 20'd0;
               end else begin
                  cnt_d = cnt_q - 20'd1;
               end
            end
            ST_SAMPLE_B: begin
               if (proceed_s) begin
                  state_d = ST_RST_LOW;
                  cnt_d   = RST_LD;
                  retry_d = {RETRY_W{1'b0}};
               end else begin
                  state_d = ST_SETTLE;
                  cnt_d   = SETTLE_LD;
                  retry_d = retry_q + RETRY_W'(1'b1);
               end
            end
            ST_RST_LOW: begin
               if (cnt_q == 20'd0) begin
                  state_d = ST_WAKE;
                  cnt_d   = WAKE_LD;
               end else begin
                  cnt_d = cnt_q - 20'd1;
               end
            end
            ST_WAKE: begin
               if (cnt_q == 20'd0) begin
                  state_d = ST_BL_DLY;
                  cnt_d   = BL_LD;
               end else begin
                  cnt_d = cnt_q - 20'd1;
               end
            end
            ST_BL_DLY: begin
               if (cnt_q == 20'd0) begin
                  state_d = ST_RUN;
                  cnt_d   = 20'd0;
               end else begin
                  cnt_d = cnt_q - 20'd1;
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_SETTLE;
               cnt_d   = SETTLE_LD;
               retry_d = {RETRY_W{1'b0}};
            end
         endcase
      end
   end

   // Output values for the next cycle; configuration holds unless newly decoded.
   always_comb begin
      rgb_oe_d   = 1'b0;
      lcd_rst_d  = 1'b1;
      disp_en_d  = 1'b0;
      lcd_bl_d   = 1'b0;
      id_valid_d = id_valid_q;
      lcd_id_d   = lcd_id_q;
      h_disp_d   = h_disp_q;
      v_disp_d   = v_disp_q;
      pclk_sel_d = pclk_sel_q;
      if (restart) begin
         id_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_SETTLE, ST_SAMPLE_A: begin
               id_valid_d = 1'b0;
            end
            ST_SAMPLE_B: begin
               if (proceed_s) begin
                  id_valid_d = 1'b1;
                  lcd_id_d   = dec_id_s;
                  h_disp_d   = dec_h_s;
                  v_disp_d   = dec_v_s;
                  pclk_sel_d = dec_pclk_s;
               end else begin
                  id_valid_d = 1'b0;
               end
            end
            ST_RST_LOW: begin
               rgb_oe_d  = 1'b1;
               lcd_rst_d = 1'b0;
            end
            ST_WAKE: begin
               rgb_oe_d = 1'b1;
            end
            ST_BL_DLY: begin
               rgb_oe_d  = 1'b1;
               disp_en_d = 1'b1;
            end
            ST_RUN: begin
               rgb_oe_d  = 1'b1;
               disp_en_d = 1'b1;
               lcd_bl_d  = bl_on_s;
            end
            default: begin
               id_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State, counter and output registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= ST_SETTLE;
         cnt_q      <= SETTLE_LD;
         retry_q    <= {RETRY_W{1'b0}};
         strap_a_q  <= 3'b000;
         strap_b_q  <= 3'b000;
         rgb_oe_q   <= 1'b0;
         lcd_id_q   <= 16'h0000;
         id_valid_q <= 1'b0;
         h_disp_q   <= H_480;
         v_disp_q   <= V_272;
         pclk_sel_q <= PCLK_SEL_480X272;
         lcd_rst_q  <= 1'b1;
         disp_en_q  <= 1'b0;
         lcd_bl_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         strap_a_q  <= strap_a_d;
         strap_b_q  <= strap_b_d;
         rgb_oe_q   <= rgb_oe_d;
         lcd_id_q   <= lcd_id_d;
         id_valid_q <= id_valid_d;
         h_disp_q   <= h_disp_d;
         v_disp_q   <= v_disp_d;
         pclk_sel_q <= pclk_sel_d;
         lcd_rst_q  <= lcd_rst_d;
         disp_en_q  <= disp_en_d;
         lcd_bl_q   <= lcd_bl_d;
      end
   end

   assign rgb_oe   = rgb_oe_q;
   assign lcd_id   = lcd_id_q;
   assign id_valid = id_valid_q;
   assign h_disp   = h_disp_q;
   assign v_disp   = v_disp_q;
   assign pclk_sel = pclk_sel_q;
   assign lcd_rst  = lcd_rst_q;
   assign disp_en  = disp_en_q;
   assign lcd_bl   = lcd_bl_q;

endmodule

// File: doc/lcd_panel_ctrl.md
# lcd_panel_ctrl

Power-up and configuration sequencer for the RGB LCD path, in the `sys_clk` domain between the pad buffers and the timing driver.
- Holds the RGB bus tri-stated while it reads the panel strap pins and decodes the panel ID.
- Drives the configuration that the clock divider and timing generator consume.
- Sequences panel reset, display enable and backlight, and owns the output-enable that goes to the RGB IOBUF `T` pins.

## Interface
Parameters:
- `SETTLE_CYC`, 1000: cycles with the bus released before the first strap sample.
- `SAMPLE_GAP`, 64: cycles between the two confirming strap samples.
- `MAX_RETRY`, 7: sample mismatches tolerated before falling back to the unknown-panel default.
- `RST_CYC`, 5000: `lcd_rst` low width.
- `WAKE_CYC`, 250000: cycles from `lcd_rst` release to `disp_en`.
- `BL_DLY_CYC`, 10000: cycles from `disp_en` to backlight on.

Ports:
- `sys_clk` in 1: single clock.
- `sys_rst` in 1: reset, synchronous, active-high.
- `restart` in 1: single-cycle pulse; re-runs the full sequence.
- `lcd_rgb_i` in 24: pad input side of the RGB IOBUFs.
- `bl_duty` in 8: backlight duty, 0..255 (used only with `LCD_BL_PWM_EN`).
- `rgb_oe` out 1: 1 = drive RGB pads (IOBUF `T` = `~rgb_oe`).
- `lcd_id` out 16: decoded panel ID.
- `id_valid` out 1: `lcd_id`, `h_disp`, `v_disp` and `pclk_sel` are stable.
- `h_disp` out 11: active width.
- `v_disp` out 11: active height.
- `pclk_sel` out 2: pixel-clock select for the divider.
- `lcd_rst` out 1: panel reset, active-low.
- `disp_en` out 1: enables the timing generator.
- `lcd_bl` out 1: backlight.

## Operation
- FSM states: `SETTLE → SAMPLE_A → SAMPLE_B → RST_LOW → WAKE → BL_DLY → RUN`.
- Reset state is `SETTLE`.
- One shared down-counter, 20 bits, reloaded on every state entry.
- `SETTLE`:
  - Outputs: `rgb_oe`=0, `lcd_rst`=1, `disp_en`=0, `lcd_bl`=0, `id_valid`=0.
  - After `SETTLE_CYC` cycles, latch `strap_a = {lcd_rgb_i[23], lcd_rgb_i[15], lcd_rgb_i[7]}` (M2,M1,M0) and go to `SAMPLE_A`.
- `SAMPLE_A`:
  - Wait `SAMPLE_GAP` cycles, latch `strap_b`, go to `SAMPLE_B`.
- `SAMPLE_B` (one cycle):
  - If `strap_a == strap_b`: decode, set `id_valid`, go to `RST_LOW`.
  - Otherwise increment the retry counter and return to `SETTLE`.
  - If the retry counter is already `MAX_RETRY`, decode as unknown and proceed to `RST_LOW`.
- Strap decode, as M2M1M0 → `lcd_id`, `h_disp`×`v_disp`, `pclk_sel`:
  - 000 → 0x4342, 480×272, 0
  - 001 → 0x7084, 800×480, 1
  - 010 → 0x7016, 1024×600, 2
  - 100 → 0x4384, 800×480, 1
  - 101 → 0x1018, 1280×800, 3
  - anything else → 0x0000, 480×272, 0
- `RST_LOW`:
  - `lcd_rst`=0 for `RST_CYC` cycles.
  - `rgb_oe` goes to 1 on entry and stays 1 through `RUN`.
- `WAKE`: `lcd_rst`=1; wait `WAKE_CYC` cycles.
- `BL_DLY`: `disp_en`=1; wait `BL_DLY_CYC` cycles.
- `RUN`: `lcd_bl` on; remain here until `restart` or reset.
- `restart`:
  - In any state except `SETTLE`: next cycle is `SETTLE` with all `SETTLE` outputs; the retry counter clears.
  - In `SETTLE`: the counter reloads.
- Configuration outputs hold their last values while `id_valid`=0, so consumers must gate on `id_valid`.

## Timing
- Every output is registered.
- Reset values: `rgb_oe`=0, `lcd_id`=0, `id_valid`=0, `h_disp`=480, `v_disp`=272, `pclk_sel`=0, `lcd_rst`=1, `disp_en`=0, `lcd_bl`=0.
- A counter-driven state lasting N cycles exits on the cycle its counter reaches 0.
  - N=0 is treated as 1.
- `id_valid` rises on the cycle after `SAMPLE_B`, together with the decoded outputs.
- `rgb_oe` rises one cycle later, on entry to `RST_LOW`.
- `sys_rst` asserted mid-sequence: next edge returns every output to its reset value, regardless of state.
- `restart` and `sys_rst` in the same cycle: reset wins.
- Nominal latency from reset release to `lcd_bl`=1, with matching straps:
  - SETTLE_CYC + SAMPLE_GAP + 1 + RST_CYC + WAKE_CYC + BL_DLY_CYC + 1 cycles.

## Configuration
- `LCD_BL_PWM_EN` defined:
  - 8-bit free-running PWM counter.
  - In `RUN`, `lcd_bl` = (`pwm_cnt` < `bl_duty`), registered.
  - `bl_duty`=0 gives constant 0.
  - `bl_duty`=255 gives high for 255 of every 256 cycles.
- `LCD_BL_PWM_EN` undefined:
  - `lcd_bl` is a constant 1 in `RUN`.
  - `bl_duty` is ignored and the PWM logic is absent.

## Structure
- Package `lcd_pkg`:
  - State enum.
  - Strap decode constants (the ID and resolution pairs).
  - `pclk_sel` encodings.
- Sub-module `lcd_strap_decode`: combinational 3-bit strap → {`lcd_id`, `h_disp`, `v_disp`, `pclk_sel`}.
- Everything else stays in `lcd_panel_ctrl`.

## Test plan
Run all scenarios with small parameters: SETTLE_CYC=4, SAMPLE_GAP=2, RST_CYC=3, WAKE_CYC=5, BL_DLY_CYC=2.
- Straps 001 held constant → `lcd_id`=0x7084, 800×480, `pclk_sel`=1.
  - `lcd_rst` low for exactly 3 cycles.
  - `lcd_bl`=1 at the computed latency of 4+2+1+3+5+2+1=18 cycles after reset release.
- Strap M0 toggles between samples once, then is stable at 101 → one retry, then `lcd_id`=0x1018, 1280×800.
- Straps alternate on every sample → after 8 mismatches, `lcd_id`=0x0000, 480×272, and the sequence still completes.
- `restart` pulse in `RUN` → next cycle `rgb_oe`=0, `disp_en`=0, `lcd_bl`=0, `id_valid`=0; straps 010 then give 0x7016.
- `sys_rst` asserted during `WAKE` → all outputs at their reset values next cycle; the sequence restarts from `SETTLE`.
- With `LCD_BL_PWM_EN` and `bl_duty`=64 in `RUN` → `lcd_bl` high for 64 of every 256 cycles.
